regfile_cmd_ctrl: RTL and testbench
===================================

Name: regfile_cmd_ctrl

Overview:
Command sequencer placed directly upstream of the 8x16 register file. It receives a byte stream from the serial receive path and decodes write and read commands. It drives the register file's WrData, Address, WrEn and RdEn, then returns read data as two bytes on a valid/ready transmit interface. It is the only master of the register file.

Parameters:
BYTE_W, 8, width of the receive and transmit byte buses
ADDR_W, 3, register file address width (must match the register file)
MEM_W, 16, register file word width; fixed at 2*BYTE_W
WR_CMD, 8'hAA, write command opcode
RD_CMD, 8'hBB, read command opcode

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  asynchronous, active-high reset
RX_P_DATA  in  BYTE_W  received byte
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid in this cycle
RdData  in  MEM_W  register file read data; valid the cycle after RdEn
WrData  out  MEM_W  register file write data
Address  out  ADDR_W  register file address
WrEn  out  1  register file write enable, one-cycle pulse
RdEn  out  1  register file read enable, one-cycle pulse
TX_P_DATA  out  BYTE_W  byte to transmit
TX_D_VLD  out  1  TX_P_DATA is valid
TX_READY  in  1  consumer accepts the byte when TX_D_VLD and TX_READY are both high at a rising edge
CMD_ERR  out  1  one-cycle pulse when a command is dropped

Behaviour:
- All outputs are registered. While RST is high every output is 0 and the FSM is in IDLE. Reset asserted mid-command aborts the command immediately; no partial WrEn is issued.
- FSM states: IDLE, WR_ADDR, WR_LSB, WR_MSB, WR_EXEC, RD_ADDR, RD_EXEC, RD_CAP, TX_LSB, TX_MSB.
- IDLE:
  - RX_D_VLD with WR_CMD -> WR_ADDR.
  - RX_D_VLD with RD_CMD -> RD_ADDR.
  - Any other byte is silently ignored (no CMD_ERR).
- WR_ADDR / RD_ADDR:
  - On the next RX_D_VLD, latch byte[ADDR_W-1:0] into Address.
  - If byte[BYTE_W-1:ADDR_W] is non-zero, pulse CMD_ERR and return to IDLE.
  - Otherwise go to WR_LSB or RD_EXEC respectively.
- WR_LSB: the next RX_D_VLD byte is latched into WrData[7:0] -> WR_MSB.
- WR_MSB: the next RX_D_VLD byte is latched into WrData[15:8] -> WR_EXEC.
- WR_EXEC: WrEn=1 for exactly one cycle, RdEn=0 -> IDLE. WrEn is high in the cycle after the MSB byte strobe. Address and WrData hold their values until the next command overwrites them.
- RD_EXEC: RdEn=1 for exactly one cycle (the cycle after the address strobe) -> RD_CAP.
- RD_CAP: capture RdData into an internal 16-bit holding register -> TX_LSB.
- TX_LSB:
  - Drive TX_D_VLD=1 with TX_P_DATA = hold[7:0].
  - Hold both until TX_READY is sampled high, then go to TX_MSB with TX_P_DATA = hold[15:8].
  - There is no gap cycle: TX_D_VLD stays high across the byte change.
- TX_MSB: on TX_READY -> TX_D_VLD=0 -> IDLE.
- First-byte latency: TX_D_VLD rises 3 cycles after the address strobe.
- TX_READY may stay low indefinitely; data and valid must stay stable while it is low.
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_CAP, TX_LSB or TX_MSB is dropped. There is no buffering and no CMD_ERR.
- WrEn and RdEn are never high in the same cycle.
- WR_CMD or RD_CMD arriving as an address or data byte is treated as data, not as a new command.
- Command bytes need not be back-to-back; idle cycles between strobes are allowed in every RX-waiting state.

Test Plan:
- Reset: RST high for 2 cycles with random RX activity -> all outputs 0; no WrEn or RdEn pulses.
- Write/read-back: send AA,00,7F,00 then BB,00 -> one WrEn with Address=0 and WrData=16'd127. On readback, TX bytes 7F then 00, and RdEn is one cycle wide, 1 cycle after the address strobe.
- Multi-address: write 623@2, 716@5, 6120@7, then read each address -> TX pairs are (6F,02), (CC,02), (E8,17).
- Bad address: send AA,08 -> CMD_ERR pulse, FSM returns to IDLE. A following AA,03,01,00 writes 1 to address 3 normally.
- Backpressure: read of address 7 with TX_READY held low for 5 cycles -> TX_P_DATA=E8 stable with TX_D_VLD high. After TX_READY goes high, 17 is sent, then TX_D_VLD falls. RX bytes sent during transmission are ignored.
- Reset mid-write: send AA,01,55, then pulse RST -> no WrEn. A subsequent read of address 1 returns the prior contents.

Source files
------------

// File: rtl/regfile_cmd_ctrl.sv
// Command sequencer for the 8x16 register file: decodes write/read byte commands from the
// receive path and returns read data as two bytes on a valid/ready transmit port.
module regfile_cmd_ctrl #(
  parameter int unsigned         BYTE_W = 8,
  parameter int unsigned         ADDR_W = 3,
  parameter int unsigned         MEM_W  = 16,
  parameter logic [BYTE_W-1:0]   WR_CMD = 8'hAA,
  parameter logic [BYTE_W-1:0]   RD_CMD = 8'hBB
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [MEM_W-1:0]  RdData,
  output logic [MEM_W-1:0]  WrData,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic              RdEn,
  output logic [BYTE_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_READY,
  output logic              CMD_ERR
);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrLsb, StWrMsb, StWrExec,
    StRdAddr, StRdExec, StRdCap, StTxLsb, StTxMsb
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_W-1:0]    wdata_q, wdata_d;
  logic [MEM_W-1:0]    hold_q, hold_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic                wren_q, wren_d;
  logic                rden_q, rden_d;
  logic                err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_d = StWrAddr;
          else if (RX_P_DATA == RD_CMD) state_d = StRdAddr;
        end
      end
      StWrAddr, StRdAddr: begin
        if (RX_D_VLD) begin
          addr_d = RX_P_DATA[ADDR_W-1:0];
          // Address bytes with bits above the register file range are rejected.
          if (|RX_P_DATA[BYTE_W-1:ADDR_W]) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = (state_q == StWrAddr) ? StWrLsb : StRdExec;
          end
        end
      end
      StWrLsb: begin
        if (RX_D_VLD) begin
          wdata_d[BYTE_W-1:0] = RX_P_DATA;
          state_d             = StWrMsb;
        end
      end
      StWrMsb: begin
        if (RX_D_VLD) begin
          wdata_d[MEM_W-1:BYTE_W] = RX_P_DATA;
          state_d                 = StWrExec;
        end
      end
      StWrExec: state_d = StIdle;
      StRdExec: state_d = StRdCap;
      StRdCap: begin
        hold_d    = RdData;
        tx_data_d = RdData[BYTE_W-1:0];
        state_d   = StTxLsb;
      end
      StTxLsb: begin
        if (TX_READY) begin
          tx_data_d = hold_q[MEM_W-1:BYTE_W];
          state_d   = StTxMsb;
        end
      end
      StTxMsb: begin
        if (TX_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_comb begin
    wren_d   = (state_d == StWrExec);
    rden_d   = (state_d == StRdExec);
    tx_vld_d = (state_d == StTxLsb) || (state_d == StTxMsb);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      err_q     <= err_d;
    end
  end

  assign WrData    = wdata_q;
  assign Address   = addr_q;
  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a behavioural 8x16 register file attached.
module tb_regfile_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [15:0] RdData;
  logic [15:0] WrData;
  logic [2:0]  Address;
  logic        WrEn;
  logic        RdEn;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY;
  logic        CMD_ERR;

  regfile_cmd_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RdData    (RdData),
    .WrData    (WrData),
    .Address   (Address),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_READY  (TX_READY),
    .CMD_ERR   (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Register file: synchronous write, read data valid the cycle after RdEn.
  logic [15:0] mem [8];
  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    if (RdEn) RdData <= mem[Address];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Monitor samples on the falling edge; inputs change 2 ns after the rising edge.
  int   cyc = 0, strobe_cyc = 0, rd_lat = -1, tx_lat = -1;
  int   wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [2:0]  last_wa;
  logic [15:0] last_wd;
  logic        tx_vld_prev = 1'b0;
  logic [7:0]  txq[$];

  always @(negedge CLK) begin
    cyc++;
    if (RX_D_VLD) strobe_cyc = cyc;
    if (WrEn) begin
      wr_cnt++;
      last_wa = Address;
      last_wd = WrData;
    end
    if (RdEn) begin
      rd_cnt++;
      rd_lat = cyc - strobe_cyc;
    end
    if (WrEn && RdEn) both_cnt++;
    if (CMD_ERR) err_cnt++;
    if (TX_D_VLD && !tx_vld_prev) tx_lat = cyc - strobe_cyc;
    tx_vld_prev = TX_D_VLD;
    if (TX_D_VLD && TX_READY) txq.push_back(TX_P_DATA);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #2;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #2;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    send_byte(8'hAA);
    send_byte({5'b0, a});
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    repeat (3) @(posedge CLK);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 60 && txq.size() < n; i++) @(posedge CLK);
  endtask

  task automatic do_read(input string tag, input logic [2:0] a, input logic [7:0] lsb,
                         input logic [7:0] msb);
    int rd0;
    rd0 = rd_cnt;
    txq.delete();
    send_byte(8'hBB);
    send_byte({5'b0, a});
    wait_tx(2);
    check({tag, " tx count"}, txq.size(), 2);
    if (txq.size() >= 2) begin
      check({tag, " lsb"}, txq[0], lsb);
      check({tag, " msb"}, txq[1], msb);
    end
    check({tag, " rden pulses"}, rd_cnt - rd0, 1);
    check({tag, " rden latency"}, rd_lat, 1);
    check({tag, " tx latency"}, tx_lat, 3);
    repeat (2) @(negedge CLK);
    check({tag, " tx_vld low"}, TX_D_VLD, 0);
  endtask

  int wr0, err0;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    RdData    = 16'h0000;
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_READY  = 1'b1;

    // Reset with random receive activity.
    repeat (2) begin
      @(posedge CLK); #2;
      RX_D_VLD  = 1'($urandom_range(0, 1));
      RX_P_DATA = 8'($urandom);
      @(negedge CLK);
      check("reset outputs", {WrData, Address, WrEn, RdEn, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    end
    @(posedge CLK); #2;
    RX_D_VLD = 1'b0;
    RST      = 1'b0;
    check("reset wr/rd pulses", wr_cnt + rd_cnt, 0);

    // Write then read back.
    do_write(3'd0, 16'd127);
    check("wr0 pulses", wr_cnt, 1);
    check("wr0 addr", last_wa, 0);
    check("wr0 data", last_wd, 16'd127);
    check("wr0 hold addr", Address, 0);
    check("wr0 hold data", WrData, 16'd127);
    do_read("rd0", 3'd0, 8'h7F, 8'h00);

    // Several addresses.
    do_write(3'd2, 16'd623);
    do_write(3'd5, 16'd716);
    do_write(3'd7, 16'd6120);
    check("multi wr pulses", wr_cnt, 4);
    do_read("rd2", 3'd2, 8'h6F, 8'h02);
    do_read("rd5", 3'd5, 8'hCC, 8'h02);
    do_read("rd7", 3'd7, 8'hE8, 8'h17);

    // Out-of-range address byte.
    wr0  = wr_cnt;
    err0 = err_cnt;
    send_byte(8'hAA);
    send_byte(8'h08);
    repeat (3) @(negedge CLK);
    check("bad addr err pulse", err_cnt - err0, 1);
    do_write(3'd3, 16'h0001);
    check("after err wr pulses", wr_cnt - wr0, 1);
    check("after err wr addr", last_wa, 3);
    check("after err wr data", last_wd, 16'h0001);
    do_read("rd3", 3'd3, 8'h01, 8'h00);

    // Backpressure on address 7, with ignored receive bytes during transmit.
    wr0 = wr_cnt;
    txq.delete();
    TX_READY = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h07);
    for (int i = 0; i < 20 && !TX_D_VLD; i++) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp vld", TX_D_VLD, 1);
      check("bp data", TX_P_DATA, 8'hE8);
    end
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge CLK);
    check("bp data after rx", TX_P_DATA, 8'hE8);
    @(posedge CLK); #2;
    TX_READY = 1'b1;
    wait_tx(2);
    check("bp tx count", txq.size(), 2);
    if (txq.size() >= 2) begin
      check("bp lsb", txq[0], 8'hE8);
      check("bp msb", txq[1], 8'h17);
    end
    repeat (2) @(negedge CLK);
    check("bp vld fall", TX_D_VLD, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (3) @(negedge CLK);
    check("bp no write", wr_cnt - wr0, 0);

    // Reset in the middle of a write.
    do_write(3'd1, 16'h1234);
    wr0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h55);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("midrst no write", wr_cnt - wr0, 0);
    do_read("rd1", 3'd1, 8'h34, 8'h12);

    check("wren rden overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
